// File: rtl/reservation_station_if.sv
// Opcode package and the bus bundle between issue logic, the CDB, the
// reservation station and the ALU.
//
// Package lc3b_types: lc3b_opcode enum (LC-3b 4-bit opcode encoding).
// Interface reservation_station_if #(DEPTH, TAG_W):
//   issue side : flush, WE, inst, src1_*/src2_* {data, tag, valid}, dest_tag
//   CDB        : CDB_in {valid, tag, data}
//   ALU side   : fu_ready in; dispatch_{valid, inst, a, b, tag} out
//   status     : full_out, count_out
//   modports   : master (issue/ALU environment), slave (reservation station)

package lc3b_types;
    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;
endpackage

interface reservation_station_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
);
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [15:0]      data;
    } cdb_t;

    logic                       flush;
    logic                       WE;
    lc3b_types::lc3b_opcode     inst;
    logic [15:0]                src1_data;
    logic [TAG_W-1:0]           src1_tag;
    logic                       src1_valid;
    logic [15:0]                src2_data;
    logic [TAG_W-1:0]           src2_tag;
    logic                       src2_valid;
    logic [TAG_W-1:0]           dest_tag;
    cdb_t                       CDB_in;
    logic                       fu_ready;
    logic                       full_out;
    logic [$clog2(DEPTH+1)-1:0] count_out;
    logic                       dispatch_valid;
    lc3b_types::lc3b_opcode     dispatch_inst;
    logic [15:0]                dispatch_a;
    logic [15:0]                dispatch_b;
    logic [TAG_W-1:0]           dispatch_tag;

    modport master (
        output flush, WE, inst, src1_data, src1_tag, src1_valid,
               src2_data, src2_tag, src2_valid, dest_tag, CDB_in, fu_ready,
        input  full_out, count_out, dispatch_valid, dispatch_inst,
               dispatch_a, dispatch_b, dispatch_tag
    );

    modport slave (
        input  flush, WE, inst, src1_data, src1_tag, src1_valid,
               src2_data, src2_tag, src2_valid, dest_tag, CDB_in, fu_ready,
        output full_out, count_out, dispatch_valid, dispatch_inst,
               dispatch_a, dispatch_b, dispatch_tag
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station for the single ALU of the Tomasulo LC-3b core.
// Buffers issued operations until both source operands are known (captured
// at issue, forwarded from the CDB at issue, or snooped from the CDB later),
// then sends the oldest ready one to the ALU, one per cycle.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high, clears all state (priority over flush)
//   rs_if  : reservation_station_if.slave (issue, CDB, ALU dispatch, status)

module reservation_station
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    reservation_station_if.slave rs_if
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage; only busy is reset, the payload is qualified by busy.
    logic [DEPTH-1:0] busy, r1, r2;
    logic [15:0]      v1 [DEPTH];
    logic [15:0]      v2 [DEPTH];
    logic [TAG_W-1:0] q1 [DEPTH];
    logic [TAG_W-1:0] q2 [DEPTH];
    logic [TAG_W-1:0] dest [DEPTH];
    lc3b_opcode       inst_q [DEPTH];
    // age = number of still-busy entries issued before this one, so ages of
    // busy entries are unique and the oldest entry has the smallest age.
    logic [IW-1:0]    age [DEPTH];

    logic [CW-1:0]    count_q;
    logic             full_q;
    logic             dv_q;
    lc3b_opcode       d_inst_q;
    logic [15:0]      d_a_q, d_b_q;
    logic [TAG_W-1:0] d_tag_q;

    logic             free_found, sel_found;
    logic [IW-1:0]    free_idx, sel_idx, sel_age, new_age;
    logic             do_issue, do_disp, fwd1, fwd2;
    logic [CW-1:0]    count_nxt;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && r1[i] && r2[i] && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = age[i];
            end
        end

        // Free slot is chosen from pre-edge state, so a slot being vacated
        // by this edge's dispatch is never reused at the same edge.
        do_issue  = rs_if.WE && !full_q && free_found;
        do_disp   = rs_if.fu_ready && sel_found;
        count_nxt = count_q + CW'(do_issue) - CW'(do_disp);
        new_age   = IW'(count_q - CW'(do_disp));

        fwd1 = !rs_if.src1_valid && rs_if.CDB_in.valid && (rs_if.CDB_in.tag == rs_if.src1_tag);
        fwd2 = !rs_if.src2_valid && rs_if.CDB_in.valid && (rs_if.CDB_in.tag == rs_if.src2_tag);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            dv_q     <= 1'b0;
            d_inst_q <= op_add;
            d_a_q    <= '0;
            d_b_q    <= '0;
            d_tag_q  <= '0;
        end else if (rs_if.flush) begin
            busy    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // CDB snoop on waiting operands
                if (busy[i] && !r1[i] && rs_if.CDB_in.valid && q1[i] == rs_if.CDB_in.tag) begin
                    v1[i] <= rs_if.CDB_in.data;
                    r1[i] <= 1'b1;
                end
                if (busy[i] && !r2[i] && rs_if.CDB_in.valid && q2[i] == rs_if.CDB_in.tag) begin
                    v2[i] <= rs_if.CDB_in.data;
                    r2[i] <= 1'b1;
                end
                // Keep ages compact as older entries leave.
                if (do_disp && busy[i] && age[i] > sel_age)
                    age[i] <= age[i] - 1'b1;
                if (do_disp && sel_idx == IW'(i))
                    busy[i] <= 1'b0;
                if (do_issue && free_idx == IW'(i)) begin
                    busy[i]   <= 1'b1;
                    inst_q[i] <= rs_if.inst;
                    q1[i]     <= rs_if.src1_tag;
                    q2[i]     <= rs_if.src2_tag;
                    r1[i]     <= rs_if.src1_valid || fwd1;
                    r2[i]     <= rs_if.src2_valid || fwd2;
                    v1[i]     <= rs_if.src1_valid ? rs_if.src1_data : rs_if.CDB_in.data;
                    v2[i]     <= rs_if.src2_valid ? rs_if.src2_data : rs_if.CDB_in.data;
                    dest[i]   <= rs_if.dest_tag;
                    age[i]    <= new_age;
                end
            end

            dv_q <= do_disp;
            if (do_disp) begin
                d_inst_q <= inst_q[sel_idx];
                d_a_q    <= v1[sel_idx];
                d_b_q    <= v2[sel_idx];
                d_tag_q  <= dest[sel_idx];
            end

            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign rs_if.full_out       = full_q;
    assign rs_if.count_out      = count_q;
    assign rs_if.dispatch_valid = dv_q;
    assign rs_if.dispatch_inst  = d_inst_q;
    assign rs_if.dispatch_a     = d_a_q;
    assign rs_if.dispatch_b     = d_b_q;
    assign rs_if.dispatch_tag   = d_tag_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station (DEPTH=4, TAG_W=3).
// Inputs change 1 ns after the rising edge; outputs are checked there too.

module tb_reservation_station;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reservation_station_if #(.DEPTH(4), .TAG_W(3)) rs_if ();

    reservation_station #(.DEPTH(4), .TAG_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .rs_if (rs_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input lc3b_opcode op,
                         input logic s1v, input logic [15:0] s1d, input logic [2:0] s1t,
                         input logic s2v, input logic [15:0] s2d, input logic [2:0] s2t,
                         input logic [2:0] dt);
        rs_if.WE         = 1'b1;
        rs_if.inst       = op;
        rs_if.src1_valid = s1v;
        rs_if.src1_data  = s1d;
        rs_if.src1_tag   = s1t;
        rs_if.src2_valid = s2v;
        rs_if.src2_data  = s2d;
        rs_if.src2_tag   = s2t;
        rs_if.dest_tag   = dt;
    endtask

    task automatic cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
        rs_if.CDB_in.valid = v;
        rs_if.CDB_in.tag   = t;
        rs_if.CDB_in.data  = d;
    endtask

    task automatic check_disp(input string tag, input lc3b_opcode op,
                              input logic [15:0] a, input logic [15:0] b, input logic [2:0] dt);
        check({tag, "_valid"}, rs_if.dispatch_valid, 1);
        check({tag, "_inst"},  rs_if.dispatch_inst,  op);
        check({tag, "_a"},     rs_if.dispatch_a,     a);
        check({tag, "_b"},     rs_if.dispatch_b,     b);
        check({tag, "_tag"},   rs_if.dispatch_tag,   dt);
    endtask

    initial begin
        rs_if.flush = 1'b0;
        rs_if.WE    = 1'b0;
        rs_if.fu_ready = 1'b1;
        issue(op_add, 1'b0, 16'd0, 3'd0, 1'b0, 16'd0, 3'd0, 3'd0);
        rs_if.WE = 1'b0;
        cdb(1'b0, 3'd0, 16'd0);

        // Reset state
        tick();
        reset = 1'b0;
        check("rst_dv",    rs_if.dispatch_valid, 0);
        check("rst_count", rs_if.count_out, 0);
        check("rst_full",  rs_if.full_out, 0);
        check("rst_inst",  rs_if.dispatch_inst, op_add);
        check("rst_tag",   rs_if.dispatch_tag, 0);

        // Ready issue: dispatch one edge after issue
        issue(op_add, 1'b1, 16'd5, 3'd0, 1'b1, 16'd7, 3'd0, 3'd2);
        tick();
        rs_if.WE = 1'b0;
        check("ri_count1", rs_if.count_out, 1);
        check("ri_dv0",    rs_if.dispatch_valid, 0);
        tick();
        check_disp("ri", op_add, 16'd5, 16'd7, 3'd2);
        check("ri_count0", rs_if.count_out, 0);
        tick();
        check("ri_pulse", rs_if.dispatch_valid, 0);

        // CDB wakeup
        issue(op_and, 1'b0, 16'd0, 3'd3, 1'b1, 16'h00FF, 3'd0, 3'd4);
        tick();
        rs_if.WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wk_hold", rs_if.dispatch_valid, 0);
        end
        cdb(1'b1, 3'd3, 16'd15);
        tick();
        cdb(1'b0, 3'd0, 16'd0);
        check("wk_nosame", rs_if.dispatch_valid, 0);
        tick();
        check_disp("wk", op_and, 16'd15, 16'h00FF, 3'd4);

        // Issue-time forwarding
        issue(op_add, 1'b0, 16'd0, 3'd5, 1'b1, 16'd3, 3'd0, 3'd1);
        cdb(1'b1, 3'd5, 16'd24);
        tick();
        rs_if.WE = 1'b0;
        cdb(1'b0, 3'd0, 16'd0);
        tick();
        check_disp("fw", op_add, 16'd24, 16'd3, 3'd1);

        // Full / backpressure
        rs_if.fu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(op_add, 1'b1, 16'(10 + i), 3'd0, 1'b1, 16'd1, 3'd0, 3'(i));
            tick();
        end
        check("full_full",  rs_if.full_out, 1);
        check("full_count", rs_if.count_out, 4);
        issue(op_add, 1'b1, 16'd99, 3'd0, 1'b1, 16'd99, 3'd0, 3'd7);
        tick();
        rs_if.WE = 1'b0;
        check("drop_count", rs_if.count_out, 4);
        rs_if.fu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ord_dv",  rs_if.dispatch_valid, 1);
            check("ord_tag", rs_if.dispatch_tag, i);
            check("ord_a",   rs_if.dispatch_a, 10 + i);
        end
        check("ord_full0", rs_if.full_out, 0);
        tick();
        check("drop_nodisp", rs_if.dispatch_valid, 0);
        check("drop_count0", rs_if.count_out, 0);

        // Oldest-first: waiting entry woken later still goes first
        rs_if.fu_ready = 1'b0;
        issue(op_add, 1'b0, 16'd0, 3'd6, 1'b1, 16'd8, 3'd0, 3'd1);
        tick();
        issue(op_add, 1'b1, 16'd20, 3'd0, 1'b1, 16'd21, 3'd0, 3'd2);
        tick();
        rs_if.WE = 1'b0;
        cdb(1'b1, 3'd6, 16'h1234);
        tick();
        cdb(1'b0, 3'd0, 16'd0);
        rs_if.fu_ready = 1'b1;
        tick();
        check_disp("old1", op_add, 16'h1234, 16'd8, 3'd1);
        tick();
        check_disp("old2", op_add, 16'd20, 16'd21, 3'd2);

        // Simultaneous issue and dispatch keep count steady
        issue(op_add, 1'b1, 16'd30, 3'd0, 1'b1, 16'd31, 3'd0, 3'd3);
        tick();
        issue(op_add, 1'b1, 16'd40, 3'd0, 1'b1, 16'd41, 3'd0, 3'd4);
        tick();
        rs_if.WE = 1'b0;
        check("sim_tag1",  rs_if.dispatch_tag, 3);
        check("sim_count", rs_if.count_out, 1);
        tick();
        check("sim_tag2",  rs_if.dispatch_tag, 4);
        check("sim_dv",    rs_if.dispatch_valid, 1);
        check("sim_count0", rs_if.count_out, 0);

        // Flush with concurrent WE
        rs_if.fu_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            issue(op_add, 1'b1, 16'(50 + i), 3'd0, 1'b1, 16'd0, 3'd0, 3'(i));
            tick();
        end
        check("fl_pre_count", rs_if.count_out, 3);
        issue(op_add, 1'b1, 16'd77, 3'd0, 1'b1, 16'd77, 3'd0, 3'd5);
        rs_if.flush    = 1'b1;
        rs_if.fu_ready = 1'b1;
        tick();
        rs_if.flush = 1'b0;
        rs_if.WE    = 1'b0;
        check("fl_count", rs_if.count_out, 0);
        check("fl_full",  rs_if.full_out, 0);
        check("fl_dv",    rs_if.dispatch_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_nodisp", rs_if.dispatch_valid, 0);
        end

        // Reset mid-operation (with flush and WE also asserted)
        rs_if.fu_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            issue(op_and, 1'b1, 16'(60 + i), 3'd0, 1'b1, 16'd0, 3'd0, 3'(i));
            tick();
        end
        check("rs_pre_count", rs_if.count_out, 3);
        issue(op_and, 1'b1, 16'd88, 3'd0, 1'b1, 16'd88, 3'd0, 3'd6);
        reset          = 1'b1;
        rs_if.flush    = 1'b1;
        rs_if.fu_ready = 1'b1;
        tick();
        reset       = 1'b0;
        rs_if.flush = 1'b0;
        rs_if.WE    = 1'b0;
        check("rs_count", rs_if.count_out, 0);
        check("rs_full",  rs_if.full_out, 0);
        check("rs_dv",    rs_if.dispatch_valid, 0);
        check("rs_tag",   rs_if.dispatch_tag, 0);
        check("rs_a",     rs_if.dispatch_a, 0);
        check("rs_inst",  rs_if.dispatch_inst, op_add);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_nodisp", rs_if.dispatch_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Operand-wait buffer between decode/issue and a single ALU functional unit in the Tomasulo LC-3b core.
- Holds issued instructions tagged with their reorder_buffer slot and snoops the CDB for outstanding source operands.
- Sends one fully-ready instruction per cycle to the ALU; the ALU result later returns on the CDB to the reorder_buffer.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 3, tag width; matches the reorder_buffer address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  mispredict flush; invalidates all entries.
- WE  in  1  issue strobe.
- inst  in  lc3b_opcode  operation to perform.
- src1_data  in  16  operand 1 value; meaningful when src1_valid=1.
- src1_tag  in  TAG_W  ROB tag producing operand 1; meaningful when src1_valid=0.
- src1_valid  in  1  operand 1 already available.
- src2_data, src2_tag, src2_valid  in  16/TAG_W/1  same for operand 2.
- dest_tag  in  TAG_W  ROB slot allocated to this instruction.
- CDB_in  in  CDB  broadcast bus {valid, tag, data}.
- fu_ready  in  1  ALU can accept an operation this cycle.
- full_out  out  1  all entries occupied.
- count_out  out  $clog2(DEPTH+1)  occupied entries.
- dispatch_valid  out  1  registered one-cycle pulse: operation issued to the ALU.
- dispatch_inst  out  lc3b_opcode  operation.
- dispatch_a, dispatch_b  out  16  operand values.
- dispatch_tag  out  TAG_W  destination ROB tag.

Behaviour:
- Entry fields: busy, inst, v1, q1, r1 (ready), v2, q2, r2, dest, age.
- Reset: all busy=0; dispatch_valid=0; dispatch_inst=op_add; dispatch_a, dispatch_b, dispatch_tag=0; full_out=0; count_out=0.
- Issue: WE=1 and full_out=0 at the edge writes the lowest-index free entry and sets busy=1.
- Issue while full_out=1 is dropped; issue logic must check full_out before asserting WE.
- full_out and count_out are registered and reflect occupancy after the edge.
- Same-cycle CDB forwarding on issue: if srcN_valid=0, CDB_in.valid=1 and CDB_in.tag==srcN_tag, the entry is written with rN=1 and vN=CDB_in.data.
- CDB snoop: each busy entry with rN=0 and qN==CDB_in.tag under CDB_in.valid=1 captures vN=data and sets rN=1 at the edge.
- Select: among busy entries with r1&r2 (state before the edge), choose the oldest, i.e. smallest age.
- Age: per-entry issue-order counter; an entry issued at cycle t is older than one issued at t+1.
- Dispatch: if fu_ready=1 and a ready entry exists, then at the edge:
  - the entry is freed (busy=0);
  - dispatch_* are loaded from it and dispatch_valid=1 for that cycle.
  - Otherwise dispatch_valid=0 and the data outputs hold their last values.
- Latency: an entry issued with both operands valid at edge t can dispatch at edge t+1 (dispatch_valid high after t+1).
- A CDB wakeup at edge t also makes the entry dispatchable at edge t+1; there is no same-edge wakeup-and-dispatch.
- Simultaneous issue and dispatch in the same cycle are legal; count_out is unchanged.
- A slot freed by dispatch at edge t cannot be reused by an issue at that same edge.
- flush: at the edge, all busy=0, dispatch_valid=0, count_out=0, full_out=0.
  - Any concurrent WE is ignored; flush has priority over issue, dispatch and snoop.
- reset has priority over flush; reset mid-operation discards all entries.
- Operand arithmetic: none; values are passed through unmodified at 16 bits.
- Tag value 0 is a legal ROB tag; validity comes only from valid bits, never from the tag value.

Test Plan:
- Ready issue:
  - reset, then WE with inst=op_add, src1_valid=1, src1_data=5, src2_valid=1, src2_data=7, dest_tag=2, fu_ready=1.
  - Required: dispatch_valid=1 with a=5, b=7, tag=2 one edge later; count_out returns to 0.
- CDB wakeup:
  - issue op_and with src1_valid=0, src1_tag=3, src2 ready=0x00FF, dest_tag=4; hold 3 cycles (no dispatch).
  - Then drive CDB_in {valid=1, tag=3, data=15}.
  - Required: dispatch at the following edge with a=15, b=0x00FF, tag=4.
- Issue-time forwarding:
  - WE with src1_tag=5, src1_valid=0 while CDB_in {1, 5, 24} in the same cycle.
  - Required: entry ready immediately; dispatch a=24 at the next edge.
- Full/backpressure:
  - fu_ready=0, issue 4 ready ops (tags 0..3).
  - Required: full_out=1, count_out=4; a 5th WE is dropped.
  - Then fu_ready=1: dispatches occur in order 0,1,2,3 on consecutive edges.
- Oldest-first:
  - issue tag 1 waiting on tag 6, then tag 2 ready.
  - Broadcast tag 6 while tag 2 is still queued under fu_ready=0, then raise fu_ready.
  - Required: tag 1 dispatches before tag 2.
- Flush/reset:
  - with 3 entries busy, assert flush together with WE.
  - Required: count_out=0, full_out=0, dispatch_valid=0 next cycle, no later dispatch of the old or new ops.
  - Repeat with reset: same result.
